// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM type, mode decode helpers and underrun constant for spi_oversampled_slave
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } spi_state_e;

  // Word returned on MISO when the TX holding register is empty at LOAD
  localparam logic [31:0] SPI_UNDERRUN_WORD = 32'h0000_0000;

  // Idle level of SCLK for a given SPI mode
  function automatic logic spi_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  // Phase: 0 samples on the leading edge, 1 samples on the trailing edge
  function automatic logic spi_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with history flop and edge pulses
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  // Next-state of the synchronizer chain and the edge-history flop
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Chain registers; reset to the pin's inactive level so no edge is seen at release
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_oversampled_slave.sv
// rtl/spi_oversampled_slave.sv - system-clock oversampled SPI slave; SPI_OVS_SLAVE_ECHO_EN returns the last RX word on underrun
module spi_oversampled_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE   = 3,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En,
  input  logic                  i_TX_DV,
  input  logic [WORD_WIDTH-1:0] i_TX_Word,
  output logic                  o_TX_Ready,
  output logic                  o_RX_DV,
  output logic [WORD_WIDTH-1:0] o_RX_Word,
  output logic                  o_Frame_Err
);

  localparam logic CPOL  = spi_cpol(SPI_MODE);
  localparam logic CPHA  = spi_cpha(SPI_MODE);
  localparam int   CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_WIDTH - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .din   (i_SPI_Clk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .din   (i_SPI_CS_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .din   (i_SPI_MOSI),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, mosi_rise, mosi_fall};

  logic leading_edge, trailing_edge, sample_edge, drive_edge;

  // Leading edge leaves the idle level; CPHA picks which edge samples and which drives
  always_comb begin
    leading_edge  = CPOL ? sclk_fall : sclk_rise;
    trailing_edge = CPOL ? sclk_rise : sclk_fall;
    sample_edge   = CPHA ? trailing_edge : leading_edge;
    drive_edge    = CPHA ? leading_edge  : trailing_edge;
  end

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  miso_q, miso_d;
  logic                  miso_en_q, miso_en_d;
  logic                  rx_dv_q, rx_dv_d;
  logic [WORD_WIDTH-1:0] rx_word_q, rx_word_d;
  logic                  frame_err_q, frame_err_d;
  logic                  armed_q, armed_d;
  logic [1:0]            warm_q, warm_d;

  logic [WORD_WIDTH-1:0] underrun_word;
  logic [WORD_WIDTH-1:0] load_word;
  logic [WORD_WIDTH-1:0] rx_next;

`ifdef SPI_OVS_SLAVE_ECHO_EN
  assign underrun_word = rx_word_q;
`else
  assign underrun_word = SPI_UNDERRUN_WORD[WORD_WIDTH-1:0];
`endif

  assign load_word = hold_full_q ? hold_q : underrun_word;
  assign rx_next   = {rx_sr_q[WORD_WIDTH-2:0], mosi_level};

  // Next-state for the frame FSM, shift registers, TX holding register and pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    miso_en_d   = miso_en_q;
    rx_dv_d     = 1'b0;
    rx_word_d   = rx_word_q;
    frame_err_d = 1'b0;

    // CS is trusted only after the chain holds post-reset samples and CS was high
    warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | ((warm_q == 2'd2) & cs_level);

    if (i_TX_DV && !hold_full_q) begin
      hold_d      = i_TX_Word;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_en_d = 1'b0;
        miso_d    = 1'b0;
        cnt_d     = CNT_MAX;
        if (armed_q && cs_fall) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        miso_en_d = 1'b1;
        // The held word moves to the shifter, so a same-cycle strobe always fits
        hold_full_d = i_TX_DV;
        if (i_TX_DV) begin
          hold_d = i_TX_Word;
        end
        if (!CPHA) begin
          {miso_d, tx_sr_d} = {load_word, 1'b0};
        end else begin
          tx_sr_d = load_word;
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        // With CPHA=0 the trailing edge right after a word boundary belongs to the old word
        if (drive_edge && (CPHA || (cnt_q != CNT_MAX))) begin
          miso_d  = tx_sr_q[WORD_WIDTH-1];
          tx_sr_d = {tx_sr_q[WORD_WIDTH-2:0], 1'b0};
        end
        if (sample_edge) begin
          rx_sr_d = rx_next;
          if (cnt_q == '0) begin
            rx_word_d = rx_next;
            rx_dv_d   = 1'b1;
            cnt_d     = CNT_MAX;
            state_d   = LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // CS release ends the frame; a completing sample in the same cycle still counts
    if (cs_rise) begin
      if ((state_q == SHIFT) && (cnt_q != CNT_MAX) && !(sample_edge && (cnt_q == '0))) begin
        frame_err_d = 1'b1;
      end
      state_d   = IDLE;
      cnt_d     = CNT_MAX;
      miso_en_d = 1'b0;
      miso_d    = 1'b0;
    end
  end

  // Register every piece of slave state; reset aborts a frame silently
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_MAX;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_word_q   <= '0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      warm_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
      rx_dv_q     <= rx_dv_d;
      rx_word_q   <= rx_word_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      warm_q      <= warm_d;
    end
  end

  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = miso_en_q;
  assign o_TX_Ready    = ~hold_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Word     = rx_word_q;
  assign o_Frame_Err   = frame_err_q;

endmodule

// File: doc/spi_oversampled_slave.md
# spi_oversampled_slave

Fully synchronous SPI responder for 16-bit words. It oversamples SPI clock, chip select and MOSI in the system clock domain, so it needs no SPI-clock-domain logic and no asynchronous reset on chip select. It is the far end of the team's SPI master: it receives MOSI words, returns MISO words from a TX handshake, and supports back-to-back words under one chip-select assertion. It also flags truncated frames.

## Interface
- SPI_MODE, 3, SPI mode 0..3. CPOL = mode 2|3; CPHA = mode 1|3.
- WORD_WIDTH, 16, bits per word, MSB first. Legal range 2..32.
- i_Clk  in  1  system clock. Must be ≥ 8× the SPI clock frequency.
- i_Rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_SPI_Clk  in  1  SPI clock, asynchronous.
- i_SPI_CS_n  in  1  chip select, active-low, asynchronous.
- i_SPI_MOSI  in  1  serial data in, asynchronous.
- o_SPI_MISO  out  1  serial data out.
- o_SPI_MISO_En  out  1  MISO output enable; high only while CS is synchronized-low.
- i_TX_DV  in  1  load strobe for i_TX_Word. Accepted only when o_TX_Ready=1.
- i_TX_Word  in  WORD_WIDTH  next word to return on MISO.
- o_TX_Ready  out  1  TX holding register empty.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Word is valid.
- o_RX_Word  out  WORD_WIDTH  last complete received word. Held until the next o_RX_DV.
- o_Frame_Err  out  1  one-cycle pulse when CS rises mid-word.

## Operation
- **Synchronizers:** each of SCLK, CS_n and MOSI passes through 2 flops, then one history flop for edge detection.
- **Edge definitions:** a leading edge is a synchronized SCLK transition away from CPOL; a trailing edge is a transition back to CPOL.
- **Sample and drive edges:**
  - CPHA=0: sample on leading, drive on trailing.
  - CPHA=1: drive on leading, sample on trailing.
- **FSM states:** IDLE, SHIFT, LOAD.
  - IDLE: MISO_En=0, bit counter = WORD_WIDTH-1. On CS falling → LOAD.
  - LOAD (1 cycle): holding register → TX shift register. If no word is held, load underrun value 0. Set o_TX_Ready=1, because the holding register is now free. For CPHA=0, drive the MSB immediately. → SHIFT.
  - SHIFT: on each sample edge, shift the synchronized MOSI into the RX shift register and decrement the counter.
    - On each drive edge, present the next TX bit. For CPHA=1, the first leading edge presents the MSB.
    - Sample edge with counter = 0: copy RX shift register → o_RX_Word, pulse o_RX_DV, reload counter, → LOAD (back-to-back word).
  - Any state, CS rising: → IDLE. If in SHIFT with counter ≠ WORD_WIDTH-1, pulse o_Frame_Err and discard the partial word (no o_RX_DV). A partial TX word is also discarded. The holding register is retained.
- **TX handshake:**
  - i_TX_DV while o_TX_Ready=1: capture i_TX_Word, o_TX_Ready→0 next cycle.
  - i_TX_DV while o_TX_Ready=0: ignored, no state change.
  - i_TX_DV in the same cycle as LOAD: LOAD consumes the old holding value, and the new word is captured into the now-empty register.
- **Simultaneous events:** the final sample edge and CS rising in the same cycle count as a complete word: o_RX_DV=1, o_Frame_Err=0.
- **Reset:** i_Rst mid-frame aborts the frame without o_Frame_Err. After release, the FSM waits in IDLE until CS is seen high, then low.

## Timing
- Reset values: o_SPI_MISO=0, o_SPI_MISO_En=0, o_TX_Ready=1, o_RX_DV=0, o_RX_Word=0, o_Frame_Err=0. Synchronizers reset to CS_n=1, SCLK=CPOL, MOSI=0.
- Edge-detect latency: 3 i_Clk cycles from a pin change to the detected edge.
- o_RX_DV: asserted 1 cycle after the detected final sample edge, i.e. 4 cycles after the pin edge.
- MISO update: 1 cycle after the detected drive edge, i.e. ≤ 4 cycles after the pin edge.
- SPI clock constraint: half-period ≥ 4 i_Clk cycles, guaranteeing MISO setup before the master samples.
- CPHA=0 constraint: the master must leave ≥ 5 i_Clk cycles between CS falling and the first SCLK edge.
- Back-to-back words: zero SPI bit-time gap required. LOAD completes before the next drive edge.

## Configuration
- SPI_OVS_SLAVE_ECHO_EN
  - Defined: on underrun, LOAD uses the last received word (o_RX_Word) instead of 0.
  - Undefined: the underrun value is 0 and no echo path is built.

## Structure
- Shared package spi_pkg holds:
  - typedef for FSM state (IDLE, SHIFT, LOAD);
  - constants CPOL/CPHA derived from mode via functions spi_cpol(mode) and spi_cpha(mode);
  - the underrun constant SPI_UNDERRUN_WORD = 0.
- Sub-module spi_sync_edge: a 2-flop synchronizer plus history flop, instantiated three times. Outputs the synchronized level, rise pulse and fall pulse.

## Test plan
- Mode 3, master sends 0xA5C3, slave holds 0x1234 → exactly one o_RX_DV with o_RX_Word=0xA5C3; master receives 0x1234; o_Frame_Err stays 0.
- Mode 0, same words → identical results; MISO MSB is valid before the first leading edge.
- Two words under one CS (0x0001, 0xFFFE), second TX word loaded after the first LOAD → two o_RX_DV pulses in order; master receives both TX words.
- CS raised after 7 bits → o_Frame_Err pulses once, no o_RX_DV; the next full frame 0x5A5A is received cleanly.
- No TX word loaded → master receives 0x0000. With SPI_OVS_SLAVE_ECHO_EN defined, it receives the previous RX word.
- i_Rst pulsed mid-frame → all outputs return to reset values; the next frame (after CS high→low) is received correctly.
